stim_sequencer: RTL and testbench

Synthesizable, parametrised stimulus replay engine that drives a DUT input word from a programmable table, one entry per transfer.
- Successor to the fixed single-word, free-running per-clock opcode driver.
- Adds a write-programmed table with per-entry repeat counts and a ready/valid handshake toward the DUT.
- Adds one-shot or loop modes, start/stop control, and status outputs (pc, loop count, done).
- Sits between the bench/host programming port and the DUT input bundle; the bench slices stim_out into DUT fields.

---
 rtl/stim_pkg.sv | 29 ++
 rtl/stim_mem.sv | 39 +++
 rtl/stim_sequencer.sv | 169 ++++++++++++++++
 tb/tb_stim_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// Shared types and helpers for the stimulus replay engine.
package stim_pkg;

    // Default geometry of the replay table.
    localparam int DEF_DATA_W = 38;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_REP_W  = 8;
    localparam int DEF_LOOP_W = 16;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One table entry at the default widths; the repeat count sits above the
    // data so that a stored word is simply {rep, data}.
    typedef struct packed {
        logic [DEF_REP_W-1:0]  rep;
        logic [DEF_DATA_W-1:0] data;
    } entry_t;

    // Index width for a table of the given depth (at least one bit).
    function automatic int pc_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/stim_mem.sv
// Replay table storage: one synchronous write port and one registered read
// port. The array itself is never reset; only the read register is.
module stim_mem
    import stim_pkg::*;
#(
    parameter int WIDTH = DEF_REP_W + DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = pc_width(DEF_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Table write; no reset so contents survive a reset of the sequencer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; a read in the same cycle as a write to the same
    // index returns the old contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/stim_sequencer.sv
// Stimulus replay engine: replays a programmed table of words toward a DUT
// over a ready/valid handshake, with per-entry repeats and one-shot or loop
// modes.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | not replaying; table writable; waiting for start
//  RUN   | presenting table entries on stim_out; writes rejected
//  DONE  | one-shot replay finished; done held; table writable
module stim_sequencer
    import stim_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int REP_W  = DEF_REP_W,
    parameter int PC_W   = pc_width(DEPTH),
    parameter int LOOP_W = DEF_LOOP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [PC_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REP_W-1:0]  wr_rep,
    output logic              wr_err,
    input  logic [PC_W:0]     length,
    input  logic              mode_loop,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] stim_out,
    output logic              stim_valid,
    input  logic              stim_ready,
    output logic [PC_W-1:0]   pc,
    output logic [LOOP_W-1:0] loop_cnt,
    output logic              busy,
    output logic              done
);

    localparam logic [PC_W:0] DEPTH_L = (PC_W+1)'(DEPTH);

    state_e                    state;
    logic [PC_W:0]             len_q;
    logic                      loop_q;
    logic [REP_W-1:0]          rep_cnt;
    logic [REP_W+DATA_W-1:0]   rd_word;
    logic [REP_W-1:0]          cur_rep;

    logic                      start_acc;
    logic                      xfer;
    logic                      entry_end;
    logic                      last_entry;
    logic                      wrap;
    logic                      finish;
    logic                      rd_en;
    logic                      wr_ok;
    logic [PC_W-1:0]           pc_nxt;
    logic [PC_W:0]             len_clamped;

    // The read register holds {rep, data} of the entry currently presented.
    assign cur_rep    = rd_word[REP_W+DATA_W-1 -: REP_W];
    assign stim_out   = rd_word[DATA_W-1:0];
    assign stim_valid = (state == RUN);
    assign busy       = (state == RUN);

    // Handshake decode and next table index; stop suppresses both start and
    // any transfer in the same cycle.
    always_comb begin
        start_acc   = start && !stop && (state != RUN) && (length != '0);
        xfer        = (state == RUN) && stim_ready && !stop;
        entry_end   = xfer && (rep_cnt == cur_rep);
        last_entry  = ({1'b0, pc} == (len_q - (PC_W+1)'(1)));
        wrap        = entry_end && last_entry && loop_q;
        finish      = entry_end && last_entry && !loop_q;
        len_clamped = (length > DEPTH_L) ? DEPTH_L : length;
        wr_ok       = wr_en && (state != RUN);

        pc_nxt = pc;
        if (start_acc) begin
            pc_nxt = '0;
        end else if (entry_end && !finish) begin
            pc_nxt = last_entry ? '0 : pc + PC_W'(1);
        end

        // On a one-shot finish no read is issued, so the last word stays on
        // stim_out.
        rd_en = start_acc || (entry_end && !finish);
    end

    stim_mem #(
        .WIDTH (REP_W + DATA_W),
        .DEPTH (DEPTH),
        .AW    (PC_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_ok),
        .wr_addr (wr_addr),
        .wr_data ({wr_rep, wr_data}),
        .rd_en   (rd_en),
        .rd_addr (pc_nxt),
        .rd_data (rd_word)
    );

    // State transitions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (stop) begin
            state <= IDLE;
        end else if (start_acc) begin
            state <= RUN;
        end else if (finish) begin
            state <= DONE;
        end
    end

    // Entry index and repeat counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= '0;
            rep_cnt <= '0;
        end else begin
            pc <= pc_nxt;
            if (stop || start_acc || entry_end) begin
                rep_cnt <= '0;
            end else if (xfer) begin
                rep_cnt <= rep_cnt + REP_W'(1);
            end
        end
    end

    // Run configuration captured at start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q  <= '0;
            loop_q <= 1'b0;
        end else if (start_acc) begin
            len_q  <= len_clamped;
            loop_q <= mode_loop;
        end
    end

    // Completed-pass counter, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loop_cnt <= '0;
        end else if (start_acc) begin
            loop_cnt <= '0;
        end else if (wrap && (loop_cnt != '1)) begin
            loop_cnt <= loop_cnt + LOOP_W'(1);
        end
    end

    // Done flag and write-rejection pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done   <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && (state == RUN);
            if (stop || start_acc) begin
                done <= 1'b0;
            end else if (finish) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed bench for stim_sequencer: expected transfers are queued by the
// stimulus process and checked by an independent monitor.
module tb_stim_sequencer;

    localparam int DATA_W = 38;
    localparam int DEPTH  = 16;
    localparam int REP_W  = 8;
    localparam int PC_W   = 4;
    localparam int LOOP_W = 16;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [PC_W-1:0]   wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [REP_W-1:0]  wr_rep;
    logic              wr_err;
    logic [PC_W:0]     length;
    logic              mode_loop;
    logic              start;
    logic              stop;
    logic [DATA_W-1:0] stim_out;
    logic              stim_valid;
    logic              stim_ready;
    logic [PC_W-1:0]   pc;
    logic [LOOP_W-1:0] loop_cnt;
    logic              busy;
    logic              done;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    stim_sequencer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .REP_W  (REP_W),
        .LOOP_W (LOOP_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_rep     (wr_rep),
        .wr_err     (wr_err),
        .length     (length),
        .mode_loop  (mode_loop),
        .start      (start),
        .stop       (stop),
        .stim_out   (stim_out),
        .stim_valid (stim_valid),
        .stim_ready (stim_ready),
        .pc         (pc),
        .loop_cnt   (loop_cnt),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d, input logic [REP_W-1:0] r);
        wr_en   = 1'b1;
        wr_addr = PC_W'(a);
        wr_data = d;
        wr_rep  = r;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input int p);
        exp_t e;
        e.data = d;
        e.pc   = PC_W'(p);
        exp_q.push_back(e);
    endtask

    task automatic do_start(input int len, input logic lp);
        length    = (PC_W+1)'(len);
        mode_loop = lp;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check(name, 64'(done), 64'h1);
    endtask

    // Monitor: pops an expectation on every accepted transfer and checks that
    // a stalled word is held for the following cycle.
    initial begin : monitor
        logic              hold_pend;
        logic [DATA_W-1:0] h_out;
        logic [PC_W-1:0]   h_pc;
        exp_t              e;
        hold_pend = 1'b0;
        h_out     = '0;
        h_pc      = '0;
        forever begin
            @(negedge clk);
            if (reset && stim_valid && !stop) begin
                if (hold_pend) begin
                    check("hold_out", 64'(stim_out), 64'(h_out));
                    check("hold_pc", 64'(pc), 64'(h_pc));
                end
                if (stim_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_xfer: got stim_out %0h pc %0d, expected no transfer", stim_out, pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_data", 64'(stim_out), 64'(e.data));
                        check("xfer_pc", 64'(pc), 64'(e.pc));
                    end
                end
                hold_pend = !stim_ready;
                h_out     = stim_out;
                h_pc      = pc;
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_rep     = '0;
        length     = '0;
        mode_loop  = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        stim_ready = 1'b0;

        #12;
        check("rst_stim_out", 64'(stim_out), 64'h0);
        check("rst_valid", 64'(stim_valid), 64'h0);
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_loop_cnt", 64'(loop_cnt), 64'h0);
        check("rst_busy_done_err", 64'({busy, done, wr_err}), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // One-shot, ready held high: A, B, B, C.
        wr(0, 38'hA, 8'd0);
        wr(1, 38'hB, 8'd1);
        wr(2, 38'hC, 8'd0);
        push(38'hA, 0);
        push(38'hB, 1);
        push(38'hB, 1);
        push(38'hC, 2);
        stim_ready = 1'b1;
        do_start(3, 1'b0);
        wait_done("oneshot_done", 20);
        check("oneshot_valid_low", 64'(stim_valid), 64'h0);
        check("oneshot_out_hold", 64'(stim_out), 64'hC);
        check("oneshot_busy_low", 64'(busy), 64'h0);
        check("oneshot_count", 64'(exp_q.size()), 64'h0);

        // Backpressure: ready 1,0,0 repeating.
        stim_ready = 1'b0;
        push(38'hA, 0);
        push(38'hB, 1);
        push(38'hB, 1);
        push(38'hC, 2);
        do_start(3, 1'b0);
        for (int i = 0; i < 40 && !done; i++) begin
            stim_ready = (i % 3 == 0);
            tick();
        end
        stim_ready = 1'b0;
        check("bp_done", 64'(done), 64'h1);
        check("bp_count", 64'(exp_q.size()), 64'h0);

        // Loop mode: 10 transfers over a two-entry table.
        wr(0, 38'h11, 8'd0);
        wr(1, 38'h22, 8'd0);
        for (int i = 0; i < 10; i++) push((i % 2 == 1) ? 38'h22 : 38'h11, i % 2);
        do_start(2, 1'b1);
        stim_ready = 1'b1;
        repeat (10) tick();
        stim_ready = 1'b0;
        check("loop_cnt", 64'(loop_cnt), 64'h5);
        check("loop_pc", 64'(pc), 64'h0);
        check("loop_busy", 64'(busy), 64'h1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_valid", 64'(stim_valid), 64'h0);
        check("stop_busy", 64'(busy), 64'h0);
        check("stop_done", 64'(done), 64'h0);
        check("loop_count", 64'(exp_q.size()), 64'h0);

        // Write during RUN is rejected.
        do_start(2, 1'b1);
        wr(0, 38'h3FF, 8'd5);
        check("wr_err_pulse", 64'(wr_err), 64'h1);
        tick();
        check("wr_err_clear", 64'(wr_err), 64'h0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        push(38'h11, 0);
        stim_ready = 1'b1;
        do_start(1, 1'b0);
        wait_done("reject_done", 10);
        stim_ready = 1'b0;
        check("reject_count", 64'(exp_q.size()), 64'h0);

        // Start with length 0 leaves DONE untouched.
        do_start(0, 1'b0);
        check("len0_done", 64'(done), 64'h1);
        check("len0_busy", 64'(busy), 64'h0);

        // Length DEPTH+1 replays exactly DEPTH entries.
        for (int i = 0; i < DEPTH; i++) wr(i, DATA_W'(32'h100 + i), 8'd0);
        for (int i = 0; i < DEPTH; i++) push(DATA_W'(32'h100 + i), i);
        stim_ready = 1'b1;
        do_start(DEPTH + 1, 1'b0);
        wait_done("clamp_done", 40);
        stim_ready = 1'b0;
        tick();
        check("clamp_count", 64'(exp_q.size()), 64'h0);

        // Async reset mid-run at pc=2, table retained.
        push(38'h100, 0);
        push(38'h101, 1);
        do_start(16, 1'b0);
        stim_ready = 1'b1;
        tick();
        tick();
        stim_ready = 1'b0;
        check("arst_pre_pc", 64'(pc), 64'h2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_stim_out", 64'(stim_out), 64'h0);
        check("arst_valid_busy", 64'({stim_valid, busy}), 64'h0);
        check("arst_pc", 64'(pc), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        do_start(3, 1'b0);
        check("arst_table_kept", 64'(stim_out), 64'h100);
        check("arst_restart_valid", 64'(stim_valid), 64'h1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("arst_count", 64'(exp_q.size()), 64'h0);

        // Stop beats a transfer on the last entry of a one-shot run.
        push(38'h100, 0);
        push(38'h101, 1);
        stim_ready = 1'b1;
        do_start(3, 1'b0);
        tick();
        tick();
        check("sim_stop_pc", 64'(pc), 64'h2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        stim_ready = 1'b0;
        check("sim_stop_done", 64'(done), 64'h0);
        check("sim_stop_busy_valid", 64'({busy, stim_valid}), 64'h0);
        check("sim_stop_count", 64'(exp_q.size()), 64'h0);

        // Start together with a write to entry 0: old contents replayed first.
        wr_en     = 1'b1;
        wr_addr   = '0;
        wr_data   = 38'h3AB;
        wr_rep    = 8'd0;
        length    = 5'd1;
        mode_loop = 1'b0;
        start     = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        check("start_wr_old", 64'(stim_out), 64'h100);
        push(38'h100, 0);
        stim_ready = 1'b1;
        wait_done("start_wr_done1", 10);
        push(38'h3AB, 0);
        do_start(1, 1'b0);
        wait_done("start_wr_done2", 10);
        stim_ready = 1'b0;
        tick();
        tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
